// File: rtl/tl_client_arbiter_2to1.sv
// 2:1 TileLink-UL client arbiter: round-robin A channel with burst lock,
// client ID prepended as the top source bit, D routed back by that bit.
// Datapath is purely combinational; only the burst lock, the beat counter
// and the round-robin pointer are registered.
module tl_client_arbiter_2to1 #(
  parameter int BEAT_BYTES = 8,
  parameter int MAX_SIZE   = 6,
  parameter int IN_SRC_W   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in0_a_valid,
  output logic                      in0_a_ready,
  input  logic [113+IN_SRC_W-1:0]   in0_a_bits,
  output logic                      in0_d_valid,
  input  logic                      in0_d_ready,
  output logic [75+IN_SRC_W-1:0]    in0_d_bits,
  input  logic                      in1_a_valid,
  output logic                      in1_a_ready,
  input  logic [113+IN_SRC_W-1:0]   in1_a_bits,
  output logic                      in1_d_valid,
  input  logic                      in1_d_ready,
  output logic [75+IN_SRC_W-1:0]    in1_d_bits,
  output logic                      out_a_valid,
  input  logic                      out_a_ready,
  output logic [113+IN_SRC_W:0]     out_a_bits,
  input  logic                      out_d_valid,
  output logic                      out_d_ready,
  input  logic [75+IN_SRC_W:0]      out_d_bits
);

  localparam int A_IN_W  = 113 + IN_SRC_W;
  localparam int D_OUT_W = 76 + IN_SRC_W;
  localparam int LG_BEAT = $clog2(BEAT_BYTES);
  localparam int CW      = MAX_SIZE - LG_BEAT;   // beat counter width

  logic              r_lock;
  logic              r_owner;
  logic              r_rr_ptr;
  logic [CW-1:0]     r_beat_cnt;

  logic              w_grant;
  logic              w_sel_valid;
  logic [A_IN_W-1:0] w_sel_bits;
  logic              w_fire;
  logic [2:0]        w_opcode;
  logic [2:0]        w_size;
  logic [2:0]        w_size_cl;
  logic [CW:0]       w_beats;
  logic [CW-1:0]     w_beats_m1;
  logic              w_dst;

  // Grant: locked owner wins; otherwise the lone valid client, or rr_ptr on a tie
  always_comb begin
    w_grant = r_rr_ptr;
    if (r_lock)                          w_grant = r_owner;
    else if (in0_a_valid && !in1_a_valid) w_grant = 1'b0;
    else if (in1_a_valid && !in0_a_valid) w_grant = 1'b1;
  end

  assign w_sel_valid = w_grant ? in1_a_valid : in0_a_valid;
  assign w_sel_bits  = w_grant ? in1_a_bits  : in0_a_bits;

  assign out_a_valid = !reset && w_sel_valid;
  assign in0_a_ready = !reset && out_a_ready && !w_grant;
  assign in1_a_ready = !reset && out_a_ready &&  w_grant;
  assign w_fire      = out_a_valid && out_a_ready;

  // Client ID slots in directly above the client's own source field
  assign out_a_bits = {w_sel_bits[A_IN_W-1:104+IN_SRC_W], w_grant,
                       w_sel_bits[103+IN_SRC_W:0]};

  assign w_opcode = w_sel_bits[A_IN_W-1 -: 3];
  assign w_size   = w_sel_bits[104+IN_SRC_W +: 3];

  // Beat count of the message on the granted client; oversize clamps to MAX_SIZE
  always_comb begin
    w_size_cl  = (32'(w_size) > MAX_SIZE) ? 3'(MAX_SIZE) : w_size;
    w_beats    = '0;
    w_beats_m1 = '0;
    if (w_opcode <= 3'd3 && 32'(w_size_cl) > LG_BEAT) begin
      w_beats    = (CW+1)'(1) << (w_size_cl - 3'(LG_BEAT));
      w_beats_m1 = CW'(w_beats - (CW+1)'(1));
    end
  end

  // Burst lock, beat countdown and round-robin pointer update on A fire
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock     <= 1'b0;
      r_owner    <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_beat_cnt <= '0;
    end else if (w_fire) begin
      if (r_lock) begin
        r_beat_cnt <= r_beat_cnt - CW'(1);
        if (r_beat_cnt == CW'(1)) begin
          r_lock   <= 1'b0;
          r_rr_ptr <= ~r_owner;
        end
      end else if (w_beats_m1 != '0) begin
        r_lock     <= 1'b1;
        r_owner    <= w_grant;
        r_beat_cnt <= w_beats_m1;
      end else begin
        r_rr_ptr <= ~w_grant;
      end
    end
  end

  // D routing is stateless: the top source bit picks the client
  assign w_dst       = out_d_bits[67+IN_SRC_W];
  assign in0_d_bits  = {out_d_bits[D_OUT_W-1:68+IN_SRC_W], out_d_bits[66+IN_SRC_W:0]};
  assign in1_d_bits  = in0_d_bits;
  assign in0_d_valid = !reset && out_d_valid && !w_dst;
  assign in1_d_valid = !reset && out_d_valid &&  w_dst;
  assign out_d_ready = !reset && (w_dst ? in1_d_ready : in0_d_ready);

endmodule

// File: doc/tl_client_arbiter_2to1.md
Name: tl_client_arbiter_2to1

Overview:
- Shares one 64-bit TileLink-UL manager port between two client masters, e.g. the front-end fetch and uncached-load paths feeding the width-adapter stage ahead of the memory crossbar.
- Arbitrates the A channel round-robin, with the grant locked for the full duration of multi-beat bursts.
- Prepends a one-bit client ID to the A source field.
- Routes D responses back to the owning client by that bit.
- Combinational datapath, zero added latency; sequential state is the burst lock, the beat counter and the round-robin pointer.

Parameters:
- BEAT_BYTES, 8, data bus bytes; fixed at 8, since beat math depends on it.
- MAX_SIZE, 6, largest legal log2(transfer bytes), i.e. 8 beats max.
- IN_SRC_W, 4, client source width; output source width is IN_SRC_W+1.

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- in0_a_valid  in  1  client 0 A valid
- in0_a_ready  out  1  client 0 A ready
- in0_a_bits  in  117  {opcode[2:0],param[2:0],size[2:0],source[3:0],address[30:0],mask[7:0],data[63:0],corrupt}
- in0_d_valid  out  1  client 0 D valid
- in0_d_ready  in  1  client 0 D ready
- in0_d_bits  out  79  {opcode[2:0],param[1:0],size[2:0],source[3:0],sink,denied,data[63:0],corrupt}
- in1_a_valid / in1_a_ready / in1_a_bits / in1_d_valid / in1_d_ready / in1_d_bits: same as client 0, for client 1
- out_a_valid  out  1  manager A valid
- out_a_ready  in  1  manager A ready
- out_a_bits  out  118  A layout with source[4:0]; source[4] is the client ID
- out_d_valid  in  1  manager D valid
- out_d_ready  out  1  manager D ready
- out_d_bits  in  80  D layout with source[4:0]

Behaviour:
- Reset: sync active-high. Clears lock=0, owner=0, beat_cnt=0, rr_ptr=0 (client 0 preferred). While reset is high, all valid/ready outputs are forced to 0. Bits outputs are don't-care.
- Burst length:
  - A beats = 2^(size-3) when opcode ∈ {0,1,2,3} and size>3; otherwise 1.
  - D beats = 2^(size-3) when opcode==1 (AccessAckData) and size>3; otherwise 1.
  - size>MAX_SIZE is illegal and is treated as MAX_SIZE.
- A arbitration when unlocked:
  - grant = the valid client; if both are valid, the client at rr_ptr.
  - Grant is combinational in the same cycle. out_a_valid = granted valid.
  - in_x_a_ready = out_a_ready && grant==x. The losing client's ready is 0.
- A fire (out_a_valid && out_a_ready) on a first beat of a multi-beat burst: lock=1, owner=grant, beat_cnt=beats-1.
- While locked:
  - Only the owner is connected, even if the other client is valid.
  - Each fire decrements beat_cnt. The fire at beat_cnt==1 unlocks at the next edge.
- On the last beat of any message (including single-beat): rr_ptr = ~owner, so the other client gets priority next.
- The owner dropping valid mid-burst holds the lock. No timeout.
- out_a_bits = granted client bits with source = {grant, in_source}.
- D routing:
  - dst = out_d_bits.source[4].
  - in{dst}_d_valid = out_d_valid. out_d_ready = in{dst}_d_ready.
  - The non-destination client's d_valid is 0.
  - in_d_bits.source = out source[3:0]; all other fields pass through.
- D needs no lock: the manager guarantees burst beats are contiguous per source. No D state.
- A and D are independent. Simultaneous A fire and D fire in the same cycle is legal and has no interaction.
- Reset asserted mid-burst: lock drops immediately at the edge. Partial-burst recovery is the system's responsibility.

Test Plan:
- Both clients single-beat Get, always valid, out_a_ready=1 → grants alternate 0,1,0,1; out source[4] toggles; each client ready only on its own cycle.
- in0 PutFull size=6 (8 beats) with in1 valid throughout → 8 consecutive in0 beats, then in1 granted on cycle 9. rr_ptr=1 after the burst.
- in0 8-beat burst with in0_a_valid dropped for 3 cycles at beat 4 and in1 valid → out_a_valid=0 during the gap, in1 never granted until beat 8 fires.
- out_a_ready=0 for 5 cycles with both valid → out_a_bits stable on the rr_ptr client, no state change, no grant switch.
- D AccessAckData size=5, source=5'b1_0011 → 4 beats to in1 with source=4'b0011; in0_d_valid=0; in1_d_ready=0 backpressures out_d_ready=0.
- Assert reset at beat 3 of an in1 burst → next cycle after reset deasserts, client 0 is preferred and lock=0; during reset all valid/ready outputs read 0.
